// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline control types for destination-register tracking.
// Stage records, bubble constant, memory-wait FSM states and the destination helper.
package cpu_pipe_pkg;

  localparam logic [4:0] REG_ZERO    = 5'h0;
  localparam logic [4:0] REG_SPECIAL = 5'h9;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       isI;
    logic       regwrite;
    logic       memread;
  } stage_ctl_t;

  localparam stage_ctl_t BUBBLE = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_fsm_e;

  function automatic logic [4:0] eff_dest(input stage_ctl_t s);
    return s.isI ? s.rt : s.rd;
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline stage of control fields; 1-cycle register.
// Hold wins over bubble, bubble wins over load; no control asserted keeps contents.
module dest_stage_reg
  import cpu_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hold,
  input  logic       i_bubble,
  input  logic       i_load,
  input  stage_ctl_t i_d,
  output stage_ctl_t o_q
);

  stage_ctl_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= BUBBLE;
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_bubble) begin
      r_q <= BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_dest_tracker.sv
// Carries decode register fields through ID/EX, EX/MEM, MEM/WB; one edge per stage.
// Stalls IF/ID on load-use and on a load waiting in MEM; MEM wait freezes ID/EX and EX/MEM.
module pipe_dest_tracker
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_isI,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_flush,
  input  logic             mem_ready,
  output logic [4:0]       ID_EX_Rs,
  output logic [4:0]       ID_EX_Rt,
  output logic             EX_MEM_RegWrite,
  output logic             EX_MEM_isI,
  output logic [4:0]       EX_MEM_Rd,
  output logic [4:0]       EX_MEM_Rt,
  output logic             MEM_WB_RegWrite,
  output logic             MEM_WB_isI,
  output logic [4:0]       MEM_WB_Rd,
  output logic [4:0]       MEM_WB_Rt,
  output logic             stall_if_id,
  output logic             wb_we,
  output logic [4:0]       wb_dest,
  output logic [CNT_W-1:0] stall_count
);

  stage_ctl_t       w_id_ctl;
  stage_ctl_t       w_idex;
  stage_ctl_t       w_exmem;
  stage_ctl_t       w_memwb;
  logic [4:0]       w_id_dest;
  logic [4:0]       w_idex_dest;
  logic             w_load_use;
  logic             w_mem_load;
  logic             w_mem_stall;
  logic             w_idex_bubble;
  logic             w_unused_memwb;
  mem_fsm_e         r_state;
  logic             r_pending_flush;
  logic [CNT_W-1:0] r_stall_count;

  assign w_id_dest = id_isI ? id_rt : id_rd;

  // Reg 0 and the special source reg 9 are never written through the pipeline.
  always_comb begin
    w_id_ctl = BUBBLE;
    if (id_valid) begin
      w_id_ctl.valid    = 1'b1;
      w_id_ctl.rs       = id_rs;
      w_id_ctl.rt       = id_rt;
      w_id_ctl.rd       = id_rd;
      w_id_ctl.isI      = id_isI;
      w_id_ctl.regwrite = id_regwrite && (w_id_dest != REG_ZERO) && (w_id_dest != REG_SPECIAL);
      w_id_ctl.memread  = id_memread;
    end
  end

  assign w_idex_dest = eff_dest(w_idex);
  assign w_load_use  = id_valid && w_idex.valid && w_idex.memread && w_idex.regwrite &&
                       (((id_rs != REG_SPECIAL) && (id_rs == w_idex_dest)) ||
                        ((id_rt != REG_SPECIAL) && (id_rt == w_idex_dest)));

  // mem_ready only matters while a valid load sits in MEM.
  assign w_mem_load  = w_exmem.valid && w_exmem.memread;
  assign w_mem_stall = w_mem_load && !mem_ready;

  assign w_idex_bubble = ex_flush || r_pending_flush || w_load_use;
  assign stall_if_id   = w_mem_stall || w_load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= RUN;
      r_pending_flush <= 1'b0;
    end else begin
      case (r_state)
        RUN:      if (w_mem_stall) r_state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready)   r_state <= RUN;
        default:  r_state <= RUN;
      endcase
      // A flush seen while frozen is remembered until the advancing edge consumes it.
      if (w_mem_stall) begin
        if (ex_flush) r_pending_flush <= 1'b1;
      end else begin
        r_pending_flush <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall_if_id && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  dest_stage_reg u_id_ex (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (w_mem_stall),
    .i_bubble (w_idex_bubble),
    .i_load   (1'b1),
    .i_d      (w_id_ctl),
    .o_q      (w_idex)
  );

  dest_stage_reg u_ex_mem (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (w_mem_stall),
    .i_bubble (1'b0),
    .i_load   (1'b1),
    .i_d      (w_idex),
    .o_q      (w_exmem)
  );

  dest_stage_reg u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .i_hold   (1'b0),
    .i_bubble (w_mem_stall),
    .i_load   (1'b1),
    .i_d      (w_exmem),
    .o_q      (w_memwb)
  );

  assign w_unused_memwb = ^{w_memwb.rs, w_memwb.memread};

  assign ID_EX_Rs        = w_idex.rs;
  assign ID_EX_Rt        = w_idex.rt;
  assign EX_MEM_RegWrite = w_exmem.regwrite;
  assign EX_MEM_isI      = w_exmem.isI;
  assign EX_MEM_Rd       = w_exmem.rd;
  assign EX_MEM_Rt       = w_exmem.rt;
  assign MEM_WB_RegWrite = w_memwb.regwrite;
  assign MEM_WB_isI      = w_memwb.isI;
  assign MEM_WB_Rd       = w_memwb.rd;
  assign MEM_WB_Rt       = w_memwb.rt;
  assign wb_we           = w_memwb.valid && w_memwb.regwrite;
  assign wb_dest         = eff_dest(w_memwb);
  assign stall_count     = r_stall_count;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed bench for pipe_dest_tracker: load-use, reg 0/9 suppression, memory wait,
// flush interaction, counter saturation and asynchronous reset.
module tb_pipe_dest_tracker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_isI, id_regwrite, id_memread;
  logic          ex_flush, mem_ready;
  logic [4:0]    ID_EX_Rs, ID_EX_Rt;
  logic          EX_MEM_RegWrite, EX_MEM_isI;
  logic [4:0]    EX_MEM_Rd, EX_MEM_Rt;
  logic          MEM_WB_RegWrite, MEM_WB_isI;
  logic [4:0]    MEM_WB_Rd, MEM_WB_Rt;
  logic          stall_if_id, wb_we;
  logic [4:0]    wb_dest;
  logic [CW-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_dest_tracker #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_isI          (id_isI),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_flush        (ex_flush),
    .mem_ready       (mem_ready),
    .ID_EX_Rs        (ID_EX_Rs),
    .ID_EX_Rt        (ID_EX_Rt),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .EX_MEM_isI      (EX_MEM_isI),
    .EX_MEM_Rd       (EX_MEM_Rd),
    .EX_MEM_Rt       (EX_MEM_Rt),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .MEM_WB_isI      (MEM_WB_isI),
    .MEM_WB_Rd       (MEM_WB_Rd),
    .MEM_WB_Rt       (MEM_WB_Rt),
    .stall_if_id     (stall_if_id),
    .wb_we           (wb_we),
    .wb_dest         (wb_dest),
    .stall_count     (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_rd       = 5'd0;
    id_isI      = 1'b0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
  endtask

  task automatic id_drv(input int rs, input int rt, input int rd,
                        input int isi, input int rw, input int mr);
    id_valid    = 1'b1;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_rd       = 5'(rd);
    id_isI      = (isi != 0);
    id_regwrite = (rw != 0);
    id_memread  = (mr != 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ex_flush  = 1'b0;
    mem_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ex_flush  = 1'b0;
    mem_ready = 1'b1;
    idle();
    tick();
    check("rst_idex_rs",  32'(ID_EX_Rs), 0);
    check("rst_exmem_rw", 32'(EX_MEM_RegWrite), 0);
    check("rst_memwb_rt", 32'(MEM_WB_Rt), 0);
    check("rst_wb_we",    32'(wb_we), 0);
    check("rst_stall",    32'(stall_if_id), 0);
    check("rst_count",    32'(stall_count), 0);

    // Load to r5 followed by a consumer of r5.
    do_reset();
    id_drv(1, 5, 0, 1, 1, 1);
    tick();
    id_drv(5, 2, 7, 0, 1, 0);
    #1 check("t1_lu_stall", 32'(stall_if_id), 1);
    tick();
    check("t1_stall_once", 32'(stall_if_id), 0);
    check("t1_exmem_rt",   32'(EX_MEM_Rt), 5);
    check("t1_exmem_rw",   32'(EX_MEM_RegWrite), 1);
    tick();
    check("t1_bubble_rw",  32'(EX_MEM_RegWrite), 0);
    check("t1_wb_we",      32'(wb_we), 1);
    check("t1_wb_dest",    32'(wb_dest), 5);
    check("t1_idex_rs",    32'(ID_EX_Rs), 5);
    idle();
    tick();
    check("t1_exmem_rd",   32'(EX_MEM_Rd), 7);
    check("t1_count",      32'(stall_count), 1);

    // Reg 9 as a source never hazards; a load to reg 9 never writes.
    do_reset();
    id_drv(1, 5, 0, 1, 1, 1);
    tick();
    id_drv(9, 3, 8, 0, 1, 0);
    #1 check("t2_rs9_nostall", 32'(stall_if_id), 0);
    tick();
    id_drv(1, 9, 0, 1, 1, 1);
    tick();
    id_drv(9, 9, 4, 0, 1, 0);
    #1 check("t2_r9_nostall", 32'(stall_if_id), 0);
    tick();
    check("t2_ld9_rw", 32'(EX_MEM_RegWrite), 0);
    check("t2_ld9_rt", 32'(EX_MEM_Rt), 9);
    idle();
    tick();
    tick();
    check("t2_count", 32'(stall_count), 0);

    // Destination reg 0 / reg 9 suppression, plus a normal writer as control.
    do_reset();
    id_drv(1, 0, 0, 1, 1, 0);
    tick();
    idle();
    tick();
    check("t3_rt0_rw",  32'(EX_MEM_RegWrite), 0);
    check("t3_rt0_isI", 32'(EX_MEM_isI), 1);
    tick();
    check("t3_rt0_wbwe", 32'(wb_we), 0);
    id_drv(2, 3, 9, 0, 1, 0);
    tick();
    idle();
    tick();
    check("t3_rd9_rw", 32'(EX_MEM_RegWrite), 0);
    check("t3_rd9_rd", 32'(EX_MEM_Rd), 9);
    tick();
    check("t3_rd9_wbwe", 32'(wb_we), 0);
    id_drv(2, 3, 8, 0, 1, 0);
    tick();
    idle();
    tick();
    tick();
    check("t3_rd8_wbwe",   32'(wb_we), 1);
    check("t3_rd8_wbdest", 32'(wb_dest), 8);

    // Load waits three cycles in MEM.
    do_reset();
    id_drv(1, 6, 0, 1, 1, 1);
    tick();
    id_drv(2, 3, 4, 0, 1, 0);
    tick();
    mem_ready = 1'b0;
    id_drv(10, 11, 12, 0, 1, 0);
    #1 check("t4_wait_stall", 32'(stall_if_id), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_exmem_hold", 32'(EX_MEM_Rt), 6);
      check("t4_memwb_bub",  32'(wb_we), 0);
      check("t4_idex_hold",  32'(ID_EX_Rs), 2);
    end
    mem_ready = 1'b1;
    #1 check("t4_release", 32'(stall_if_id), 0);
    check("t4_count", 32'(stall_count), 3);
    tick();
    check("t4_wb_we",     32'(wb_we), 1);
    check("t4_wb_dest",   32'(wb_dest), 6);
    check("t4_memwb_isI", 32'(MEM_WB_isI), 1);
    check("t4_exmem_rd",  32'(EX_MEM_Rd), 4);
    check("t4_idex_rs",   32'(ID_EX_Rs), 10);

    // Flush during the wait is applied on the advancing edge only.
    do_reset();
    id_drv(1, 6, 0, 1, 1, 1);
    tick();
    id_drv(2, 3, 4, 0, 1, 0);
    tick();
    mem_ready = 1'b0;
    id_drv(10, 11, 12, 0, 1, 0);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    tick();
    check("t5_hold_in_wait", 32'(ID_EX_Rs), 2);
    mem_ready = 1'b1;
    tick();
    check("t5_flush_bubble", 32'(ID_EX_Rs), 0);
    check("t5_exmem_rd",     32'(EX_MEM_Rd), 4);
    check("t5_wb_dest",      32'(wb_dest), 6);
    check("t5_count",        32'(stall_count), 2);
    id_drv(13, 14, 15, 0, 1, 0);
    tick();
    check("t5_next_flows", 32'(ID_EX_Rs), 13);
    idle();
    tick();
    check("t5_next_exmem", 32'(EX_MEM_Rd), 15);

    // Flush together with load-use, then flush alone.
    do_reset();
    id_drv(1, 5, 0, 1, 1, 1);
    tick();
    id_drv(5, 2, 7, 0, 1, 0);
    ex_flush = 1'b1;
    #1 check("t6_flush_lu_stall", 32'(stall_if_id), 1);
    tick();
    ex_flush = 1'b0;
    check("t6_flush_lu_bub", 32'(ID_EX_Rs), 0);
    check("t6_count",        32'(stall_count), 1);
    ex_flush = 1'b1;
    #1 check("t6_flush_nostall", 32'(stall_if_id), 0);
    tick();
    ex_flush = 1'b0;
    check("t6_flush_kill", 32'(ID_EX_Rs), 0);
    tick();
    check("t6_after_flush", 32'(ID_EX_Rs), 5);

    // Long wait saturates the counter; async reset mid-wait clears everything.
    do_reset();
    id_drv(1, 6, 0, 1, 1, 1);
    tick();
    id_drv(2, 3, 4, 0, 1, 0);
    tick();
    mem_ready = 1'b0;
    ex_flush  = 1'b1;
    tick();
    ex_flush = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("t7_saturate",   32'(stall_count), 15);
    check("t7_still_wait", 32'(stall_if_id), 1);
    #2 rst = 1'b1;
    #1;
    check("t7_arst_exmem_rw", 32'(EX_MEM_RegWrite), 0);
    check("t7_arst_exmem_rt", 32'(EX_MEM_Rt), 0);
    check("t7_arst_idex_rs",  32'(ID_EX_Rs), 0);
    check("t7_arst_wb_we",    32'(wb_we), 0);
    check("t7_arst_count",    32'(stall_count), 0);
    check("t7_arst_stall",    32'(stall_if_id), 0);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    id_drv(17, 18, 19, 0, 1, 0);
    tick();
    check("t7_no_pending", 32'(ID_EX_Rs), 17);
    check("t7_run_stall",  32'(stall_if_id), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
